// File: rtl/dpram_ctrl_gen.sv
// Dual-port RAM controller: single read/write requests with busy/done handshake,
// plus a built-in write-then-readback memory test reporting pass/fail and first bad address.
module dpram_ctrl_gen #(
    parameter int                DATA_W  = 16,
    parameter int                ADDR_W  = 10,
    parameter int                DEPTH   = 1024,
    parameter int                RD_LAT  = 1,
    parameter logic [DATA_W-1:0] PATTERN = DATA_W'(16'hA5A5)
) (
    input  logic              clk,
    input  logic              ar,
    input  logic              rd,
    input  logic              wr,
    input  logic              it_start,
    input  logic [ADDR_W-1:0] a,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              done,
    output logic              busy,
    output logic              it_pass,
    output logic              it_fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_wraddress,
    output logic [ADDR_W-1:0] ram_rdaddress,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WRITE    = 3'd1;
    localparam logic [2:0] READ     = 3'd2;
    localparam logic [2:0] RWAIT    = 3'd3;
    localparam logic [2:0] IT_WR    = 3'd4;
    localparam logic [2:0] IT_RD    = 3'd5;
    localparam logic [2:0] IT_DRAIN = 3'd6;
    localparam logic [2:0] FIN      = 3'd7;

    localparam logic [1:0] OP_WR = 2'd0;
    localparam logic [1:0] OP_RD = 2'd1;
    localparam logic [1:0] OP_IT = 2'd2;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [2:0]              state;
    logic                    pend;
    logic [1:0]              op;
    logic [ADDR_W-1:0]       a_r, wcnt, rcnt;
    logic [DATA_W-1:0]       din_r, q_r;
    logic [1:0]              lat_cnt;
    logic [RD_LAT:0]         vld_pipe;
    logic [RD_LAT:0][ADDR_W-1:0] addr_pipe;
    logic                    cmp_vld, cmp_bad;
    logic [ADDR_W-1:0]       cmp_addr;

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] i);
        return DATA_W'(i) ^ PATTERN;
    endfunction

    // Acceptance only latches the request (pend); the operation starts on the next edge.
    assign busy          = pend | (state != IDLE);
    assign done          = (state == FIN);
    assign ram_wren      = (state == WRITE) | (state == IT_WR);
    assign ram_wraddress = (state == IT_WR) ? wcnt : a_r;
    assign ram_data      = (state == IT_WR) ? pat(wcnt) : din_r;
    assign ram_rdaddress = (state == IT_RD || state == IT_DRAIN) ? rcnt : a_r;

    // Compare stage sits after an extra register on ram_q, so it sees stage RD_LAT.
    assign cmp_vld  = vld_pipe[RD_LAT] & (state == IT_RD || state == IT_DRAIN);
    assign cmp_addr = addr_pipe[RD_LAT];
    assign cmp_bad  = (q_r != pat(cmp_addr));

    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
            q_r       <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[RD_LAT-1:0], state == IT_RD};
            addr_pipe <= {addr_pipe[RD_LAT-1:0], rcnt};
            q_r       <= ram_q;
        end
    end

    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            state     <= IDLE;
            pend      <= 1'b0;
            op        <= OP_WR;
            a_r       <= '0;
            din_r     <= '0;
            wcnt      <= '0;
            rcnt      <= '0;
            lat_cnt   <= '0;
            dout      <= '0;
            it_pass   <= 1'b0;
            it_fail   <= 1'b0;
            fail_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pend) begin
                        pend <= 1'b0;
                        case (op)
                            OP_WR:   state <= WRITE;
                            OP_RD:   state <= READ;
                            default: begin
                                state <= IT_WR;
                                wcnt  <= '0;
                                rcnt  <= '0;
                            end
                        endcase
                    end else if (wr | rd | it_start) begin
                        pend  <= 1'b1;
                        a_r   <= a;
                        din_r <= din;
                        if (wr)      op <= OP_WR;
                        else if (rd) op <= OP_RD;
                        else begin
                            op        <= OP_IT;
                            it_pass   <= 1'b0;
                            it_fail   <= 1'b0;
                            fail_addr <= '0;
                        end
                    end
                end
                WRITE: state <= FIN;
                READ: begin
                    lat_cnt <= '0;
                    state   <= RWAIT;
                end
                RWAIT: begin
                    if (lat_cnt == 2'(RD_LAT - 1)) begin
                        dout  <= ram_q;
                        state <= FIN;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                IT_WR: begin
                    if (wcnt == LAST) state <= IT_RD;
                    else              wcnt  <= wcnt + ADDR_W'(1);
                end
                IT_RD: begin
                    if (rcnt == LAST) state <= IT_DRAIN;
                    else              rcnt  <= rcnt + ADDR_W'(1);
                end
                IT_DRAIN: ;
                default: state <= IDLE;
            endcase
            // Overrides the read-issue transition: first mismatch or final match ends the test.
            if (cmp_vld) begin
                if (cmp_bad) begin
                    it_fail   <= 1'b1;
                    fail_addr <= cmp_addr;
                    state     <= FIN;
                end else if (cmp_addr == LAST) begin
                    it_pass <= 1'b1;
                    state   <= FIN;
                end
            end
        end
    end

endmodule

// File: tb/tb_dpram_ctrl_gen.sv
// Bench for dpram_ctrl_gen: behavioural RAM, table vectors, random ops vs. a memory model,
// and hand-written sequences for busy-ignore, memory test pass/fail and mid-test reset.
module tb_dpram_ctrl_gen;

    localparam int DW = 16, AW = 10, DEPTH = 1024, RD_LAT = 1, LIMIT = 5000;
    localparam logic [DW-1:0] PAT = 16'hA5A5;

    logic          clk = 1'b0, ar = 1'b1, rd = 1'b0, wr = 1'b0, it_start = 1'b0;
    logic [AW-1:0] a = '0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout, ram_data, ram_q;
    logic          done, busy, it_pass, it_fail, ram_wren;
    logic [AW-1:0] fail_addr, ram_wraddress, ram_rdaddress;

    int checks = 0, failures = 0;

    dpram_ctrl_gen #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .PATTERN(PAT)) dut (
        .clk(clk), .ar(ar), .rd(rd), .wr(wr), .it_start(it_start), .a(a), .din(din),
        .dout(dout), .done(done), .busy(busy), .it_pass(it_pass), .it_fail(it_fail),
        .fail_addr(fail_addr), .ram_data(ram_data), .ram_wraddress(ram_wraddress),
        .ram_rdaddress(ram_rdaddress), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    // Synchronous dual-port RAM; optional stuck bit on reads of 0x155.
    logic [DW-1:0] mem [0:1023];
    logic          mem_clr = 1'b0, fault = 1'b0;
    logic [DW-1:0] q1, q2;

    always @(posedge clk) begin
        if (mem_clr) for (int i = 0; i < 1024; i++) mem[i] <= '0;
        else if (ram_wren) mem[ram_wraddress] <= ram_data;
        q1 <= mem[ram_rdaddress] ^ ((fault && ram_rdaddress == 10'h155) ? 16'h0001 : 16'h0000);
        q2 <= q1;
    end
    assign ram_q = (RD_LAT == 2) ? q2 : q1;

    logic [DW-1:0] ref_mem [0:1023];

    typedef struct {
        logic          w;
        logic          r;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_dout;
        int            exp_lat;
        int            exp_wren;
    } vec_t;
    vec_t tbl [7];

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one request, wait for done; lat counts edges after the acceptance edge.
    task automatic run_op(input logic w, input logic r, input logic t, input logic [AW-1:0] aa,
                          input logic [DW-1:0] dd, output int lat, output int wc,
                          output logic [AW-1:0] wa, output logic [DW-1:0] wd);
        wr = w; rd = r; it_start = t; a = aa; din = dd;
        tick();
        wr = 0; rd = 0; it_start = 0;
        chk("busy_after_accept", busy, 1);
        lat = 0; wc = 0; wa = '0; wd = '0;
        while (!done && lat < LIMIT) begin
            if (ram_wren) begin wc++; wa = ram_wraddress; wd = ram_data; end
            tick();
            lat++;
        end
        chk("done_timeout", (lat < LIMIT), 1);
        tick();
        chk("done_one_cycle", done, 0);
        chk("idle_after_fin", busy, 0);
    endtask

    int lat, wc, n;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd, rdat;
    logic saw_done;

    initial begin
        #3 ar = 0;
        mem_clr = 1;
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        tick(); tick();
        mem_clr = 0;
        chk("rst_dout", dout, 0);
        chk("rst_ctl", {done, busy, it_pass, it_fail, ram_wren}, 0);
        chk("rst_addr", {fail_addr, ram_wraddress, ram_rdaddress}, 0);
        chk("rst_ram_data", ram_data, 0);
        ar = 1;
        tick();

        tbl[0] = '{1, 0, 10'h3FF, 16'h1234, 16'h0000, 2, 1};
        tbl[1] = '{0, 1, 10'h3FF, 16'h0000, 16'h1234, 2 + RD_LAT, 0};
        tbl[2] = '{1, 1, 10'h005, 16'hBEEF, 16'h1234, 2, 1};
        tbl[3] = '{0, 1, 10'h005, 16'h0000, 16'hBEEF, 2 + RD_LAT, 0};
        tbl[4] = '{1, 0, 10'h000, 16'h0001, 16'hBEEF, 2, 1};
        tbl[5] = '{0, 1, 10'h000, 16'h0000, 16'h0001, 2 + RD_LAT, 0};
        tbl[6] = '{0, 1, 10'h3FF, 16'h0000, 16'h1234, 2 + RD_LAT, 0};
        for (int i = 0; i < 7; i++) begin
            run_op(tbl[i].w, tbl[i].r, 0, tbl[i].a, tbl[i].d, lat, wc, wa, wd);
            chk($sformatf("tbl%0d_lat", i), lat, tbl[i].exp_lat);
            chk($sformatf("tbl%0d_wren", i), wc, tbl[i].exp_wren);
            chk($sformatf("tbl%0d_dout", i), dout, tbl[i].exp_dout);
            if (tbl[i].w) begin
                chk($sformatf("tbl%0d_wa", i), wa, tbl[i].a);
                chk($sformatf("tbl%0d_wd", i), wd, tbl[i].d);
                ref_mem[tbl[i].a] = tbl[i].d;
            end
        end

        // Random single ops against the memory model
        for (int i = 0; i < 40; i++) begin
            int kind;
            kind = $urandom_range(0, 2);
            ra   = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            rdat = DW'($urandom);
            run_op(kind != 1, kind != 0, 0, ra, rdat, lat, wc, wa, wd);
            if (kind == 1) begin
                chk("rnd_rd_lat", lat, 2 + RD_LAT);
                chk("rnd_rd_wren", wc, 0);
                chk("rnd_rd_dout", dout, ref_mem[ra]);
            end else begin
                chk("rnd_wr_lat", lat, 2);
                chk("rnd_wr_wren", wc, 1);
                chk("rnd_wr_addr_data", {wa, wd}, {ra, rdat});
                ref_mem[ra] = rdat;
            end
        end

        // wr pulsed while a read is in progress must be dropped
        rd = 1; a = 10'h005;
        tick();
        rd = 0;
        n = 0; wc = 0;
        while (!done && n < LIMIT) begin
            if (ram_wren) wc++;
            if (n == 0) begin wr = 1; din = 16'hDEAD; end
            else wr = 0;
            tick();
            n++;
        end
        wr = 0;
        chk("busy_wr_no_wren", wc, 0);
        chk("busy_rd_lat", n, 2 + RD_LAT);
        chk("busy_rd_dout", dout, ref_mem[5]);
        tick();
        run_op(0, 1, 0, 10'h005, 0, lat, wc, wa, wd);
        chk("busy_mem_unchanged", dout, ref_mem[5]);

        // Memory test, healthy RAM
        run_op(0, 0, 1, 10'h000, 0, lat, wc, wa, wd);
        chk("it_pass_lat", lat, 2 * DEPTH + RD_LAT + 2);
        chk("it_pass_wren", wc, DEPTH);
        chk("it_pass_flags", {it_pass, it_fail}, 2'b10);
        chk("it_pass_fail_addr", fail_addr, 0);
        for (int i = 0; i < 1024; i++) ref_mem[i] = DW'(i) ^ PAT;
        run_op(0, 1, 0, 10'h3FF, 0, lat, wc, wa, wd);
        chk("it_pattern_3ff", dout, 16'hA65A);
        for (int i = 0; i < 4; i++) begin
            ra = AW'($urandom);
            run_op(0, 1, 0, ra, 0, lat, wc, wa, wd);
            chk("it_pattern_rnd", dout, ref_mem[ra]);
        end

        // Memory test, bit 0 of 0x155 corrupted on read
        fault = 1;
        run_op(0, 0, 1, 10'h000, 0, lat, wc, wa, wd);
        fault = 0;
        chk("it_fail_flags", {it_pass, it_fail}, 2'b01);
        chk("it_fail_addr", fail_addr, 10'h155);
        chk("it_fail_early", (lat < 2 * DEPTH + RD_LAT + 2), 1);

        // Reset 100 cycles into a test
        it_start = 1;
        tick();
        it_start = 0;
        repeat (100) tick();
        ar = 0;
        #1;
        chk("midrst_ctl", {done, busy, it_pass, it_fail, ram_wren}, 0);
        chk("midrst_data", {dout, ram_data}, 0);
        chk("midrst_addr", {fail_addr, ram_wraddress, ram_rdaddress}, 0);
        saw_done = 0;
        repeat (3) begin tick(); if (done) saw_done = 1; end
        ar = 1;
        repeat (5) begin tick(); if (done) saw_done = 1; end
        chk("midrst_no_done", saw_done, 0);
        chk("midrst_idle", {busy, it_pass, it_fail}, 0);
        run_op(0, 1, 0, 10'h005, 0, lat, wc, wa, wd);
        chk("midrst_read_after", dout, ref_mem[5]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dpram_ctrl_gen.md
# dpram_ctrl_gen

Parametrised dual-port RAM controller, the successor to the fixed 16-bit / 1K-word DPRAM controller. It sits between the user/test front end and a simple dual-port synchronous RAM (one write port, one read port). It serves single read and write requests with a busy/done handshake. It also runs a built-in internal memory test, a full write-then-readback sweep, that reports pass/fail and the first failing address.

## Interface
- DATA_W, 16, data width in bits
- ADDR_W, 10, address width in bits
- DEPTH, 1024, words covered by the internal test; 2 ≤ DEPTH ≤ 2^ADDR_W
- RD_LAT, 1, RAM read latency in cycles from address registered in RAM to valid q; legal values 1 or 2
- PATTERN, 16'hA5A5 (DATA_W bits), XOR mask for the internal test data
- clk  in  1  single clock, rising edge
- ar  in  1  asynchronous reset, active low
- rd  in  1  read request, sampled when busy=0
- wr  in  1  write request, sampled when busy=0
- it_start  in  1  internal test start, sampled when busy=0
- a  in  ADDR_W  request address
- din  in  DATA_W  write data
- dout  out  DATA_W  read data, held until the next read completes
- done  out  1  one-cycle pulse on completion of a read, write or test
- busy  out  1  controller not accepting requests
- it_pass  out  1  sticky: last test passed
- it_fail  out  1  sticky: last test failed
- fail_addr  out  ADDR_W  first mismatching address of the last failed test
- ram_data  out  DATA_W  RAM write data
- ram_wraddress  out  ADDR_W  RAM write address
- ram_rdaddress  out  ADDR_W  RAM read address
- ram_wren  out  1  RAM write enable
- ram_q  in  DATA_W  RAM read data

## Operation
- States: IDLE, WRITE, READ, RWAIT, IT_WR, IT_RD, IT_DRAIN, FIN.
- In IDLE, the priority of simultaneous requests is wr > rd > it_start. Losing requests are dropped.
- Requests arriving while busy=1 are ignored and are not queued.
- Write path: IDLE -> WRITE -> FIN -> IDLE.
  - In WRITE, ram_wren=1, with ram_wraddress and ram_data equal to the a and din values registered at acceptance.
- Read path: IDLE -> READ -> RWAIT (RD_LAT cycles) -> FIN -> IDLE.
  - ram_rdaddress is driven from the registered a.
  - dout is loaded from ram_q on the edge leaving the last RWAIT cycle.
- Internal test:
  - Clears it_pass, it_fail and fail_addr on acceptance.
  - IT_WR writes P(i) = zero-extended i XOR PATTERN to addresses i = 0..DEPTH-1, one per cycle.
  - IT_RD then issues reads 0..DEPTH-1, one per cycle.
  - The expected address is delayed by a RD_LAT+1 stage pipeline, and each returned ram_q is compared against P(expected address).
  - IT_DRAIN covers the final pipeline cycles.
  - On the first mismatch: it_fail=1 and fail_addr=that address, then go to FIN immediately. Remaining reads are abandoned.
  - If all DEPTH words match: it_pass=1, then FIN.
- FIN lasts one cycle: done=1, then IDLE.
- The test leaves the RAM contents overwritten with the pattern.
- Address counters are ADDR_W bits wide and stop at DEPTH-1; they do not wrap.
- When DEPTH = 2^ADDR_W, the terminal condition is detected by compare, not by overflow.

## Timing
- Reset (ar=0, asynchronous): state=IDLE and every output is 0, including dout, busy, done, it_pass, it_fail, fail_addr and all ram_* outputs.
- Reset mid-operation aborts the operation. No done pulse is produced and no pass/fail is set.
- Acceptance edge E0: busy=1 from after E0 until the end of the FIN cycle. busy=0 in the cycle after FIN, so back-to-back requests start 1 cycle after done.
- Write: ram_wren is high between E1 and E2, and done is high between E2 and E3. Total 3 cycles from request to idle.
- Read:
  - ram_rdaddress is valid after E1.
  - dout is valid and done is high after edge E(2+RD_LAT).
  - The done pulse and the new dout appear in the same cycle.
- Test duration: done is high DEPTH (writes) + DEPTH (reads) + RD_LAT + 2 cycles after E0 on pass. It comes earlier on fail.
- ram_wren is never high outside WRITE and IT_WR.

## Test plan
- Reset asserted mid-test at 100 cycles in -> all outputs 0 at once; it_pass=0, it_fail=0; no done.
- wr with a=10'h3FF, din=16'h1234, then rd with a=10'h3FF -> ram_wren exactly 1 cycle; dout=16'h1234 with done 3 cycles after the rd edge (RD_LAT=1) and 4 cycles after (RD_LAT=2).
- rd and wr asserted together, a=5, din=16'hBEEF -> write only; single done; a subsequent read of address 5 returns 16'hBEEF.
- it_start with the default parameters and a correct RAM model -> it_pass=1, it_fail=0, done at cycle 2051 (RD_LAT=1); address 0x3FF then reads 16'hA65A.
- it_start with the RAM model forcing bit 0 of address 0x155 -> it_fail=1, fail_addr=10'h155, it_pass=0; done arrives before the sweep finishes.
- wr pulsed while busy during a read -> ignored; no ram_wren; RAM contents unchanged.
